// File: rtl/counter_updown_mod.sv
// counter_updown_mod
//   Parametrised up/down modulo counter with count enable, synchronous clear
//   and load, and a selectable wrap or saturate mode at the range limits.
//   Counting range is 0..MAX_VALUE. Per-edge priority is
//   reset > clear > load > enable > hold.
//
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   MAX_VALUE  highest count value (1 .. 2**WIDTH-1)
//   SATURATE   0 = wrap at limits, 1 = hold at limits
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   clear       synchronous clear of count, wrap and sat
//   load        load min(load_value, MAX_VALUE)
//   load_value  value to load
//   enable      count enable
//   up          1 = increment, 0 = decrement
//   count       registered count
//   at_limit    combinational: count at the limit in the current direction
//   wrap        registered one-cycle pulse after a wrap/saturation event
//   sat         registered sticky saturation flag (SATURATE=1 only)
module counter_updown_mod #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 2**WIDTH-1,
  parameter bit SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             sat_q,   sat_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (clear) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      // Clamp so the count never leaves 0..MAX_VALUE.
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (enable) begin
      if (up) begin
        if (count_q != MAX_C) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          wrap_d = 1'b1;
          if (SATURATE) sat_d = 1'b1;
          else          count_d = '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          wrap_d = 1'b1;
          if (SATURATE) sat_d = 1'b1;
          else          count_d = MAX_C;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    at_limit = up ? (count_q == MAX_C) : (count_q == '0);
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign sat   = sat_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod with three configurations:
//   a: WIDTH=4, MAX_VALUE=9,  SATURATE=0
//   b: WIDTH=4, MAX_VALUE=9,  SATURATE=1
//   c: WIDTH=4, MAX_VALUE=15, SATURATE=0
module tb_counter_updown_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_reset, a_clear, a_load, a_enable, a_up;
  logic [3:0] a_lv, a_count;
  logic       a_at_limit, a_wrap, a_sat;

  logic       b_reset, b_clear, b_load, b_enable, b_up;
  logic [3:0] b_lv, b_count;
  logic       b_at_limit, b_wrap, b_sat;

  logic       c_reset, c_clear, c_load, c_enable, c_up;
  logic [3:0] c_lv, c_count;
  logic       c_at_limit, c_wrap, c_sat;

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .reset(a_reset), .clear(a_clear), .load(a_load),
    .load_value(a_lv), .enable(a_enable), .up(a_up),
    .count(a_count), .at_limit(a_at_limit), .wrap(a_wrap), .sat(a_sat));

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .clear(b_clear), .load(b_load),
    .load_value(b_lv), .enable(b_enable), .up(b_up),
    .count(b_count), .at_limit(b_at_limit), .wrap(b_wrap), .sat(b_sat));

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(15), .SATURATE(1'b0)) dut_c (
    .clk(clk), .reset(c_reset), .clear(c_clear), .load(c_load),
    .load_value(c_lv), .enable(c_enable), .up(c_up),
    .count(c_count), .at_limit(c_at_limit), .wrap(c_wrap), .sat(c_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_reset, a_clear, a_load, a_enable, a_up, a_lv} = {5'b10001, 4'd0};
    {b_reset, b_clear, b_load, b_enable, b_up, b_lv} = {5'b10001, 4'd0};
    {c_reset, c_clear, c_load, c_enable, c_up, c_lv} = {5'b10001, 4'd0};
    tick();
    tick();

    // ---------------- reset state ----------------
    chk("a_reset_count", a_count, 0);
    chk("a_reset_wrap",  a_wrap, 0);
    chk("a_reset_sat",   a_sat, 0);
    chk("a_reset_atlim_up", a_at_limit, 0);
    a_up = 1'b0; #1;
    chk("a_reset_atlim_dn", a_at_limit, 1);
    chk("b_reset_sat", b_sat, 0);
    chk("c_reset_count", c_count, 0);

    // ---------------- a: 12 up cycles, wrap 9->0 ----------------
    a_reset = 1'b0; a_enable = 1'b1; a_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("a_up_count_%0d", i), a_count, i % 10);
      chk($sformatf("a_up_wrap_%0d", i), a_wrap, (i == 10) ? 1 : 0);
      chk($sformatf("a_up_atlim_%0d", i), a_at_limit, (i % 10 == 9) ? 1 : 0);
    end
    chk("a_sat_stays0", a_sat, 0);

    // ---------------- a: clear then count down 0->9,8,7 ----------------
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    chk("a_clear_count", a_count, 0);
    a_up = 1'b0;
    tick(); chk("a_dn_count0", a_count, 9); chk("a_dn_wrap0", a_wrap, 1);
    tick(); chk("a_dn_count1", a_count, 8); chk("a_dn_wrap1", a_wrap, 0);
    tick(); chk("a_dn_count2", a_count, 7); chk("a_dn_wrap2", a_wrap, 0);
    chk("a_dn_sat", a_sat, 0);

    // ---------------- a: load clamp and load priority ----------------
    a_enable = 1'b0; a_load = 1'b1; a_lv = 4'd14;
    tick(); chk("a_load_clamp", a_count, 9); chk("a_load_clamp_wrap", a_wrap, 0);
    a_lv = 4'd5; a_enable = 1'b1; a_up = 1'b1;
    tick(); chk("a_load_over_en", a_count, 5);
    a_load = 1'b0;
    tick(); tick();
    chk("a_pre_reset_count", a_count, 7);

    // reset beats load and enable
    a_reset = 1'b1; a_load = 1'b1; a_lv = 4'd3;
    tick(); chk("a_rst_prio_count", a_count, 0); chk("a_rst_prio_wrap", a_wrap, 0);
    a_reset = 1'b0; a_lv = 4'd4;
    tick(); chk("a_load4", a_count, 4);
    // clear beats load
    a_clear = 1'b1;
    tick(); chk("a_clr_prio_count", a_count, 0);
    a_clear = 1'b0;

    // at_limit independent of enable; hold with enable=0
    a_enable = 1'b0; a_lv = 4'd9;
    tick(); a_load = 1'b0; #1;
    chk("a_atlim_noen", a_at_limit, 1);
    tick(); chk("a_hold_count", a_count, 9); chk("a_hold_wrap", a_wrap, 0);

    // ---------------- b: saturate mode ----------------
    b_reset = 1'b0; b_load = 1'b1; b_lv = 4'd8;
    tick(); chk("b_load8", b_count, 8);
    b_load = 1'b0; b_enable = 1'b1; b_up = 1'b1;
    tick(); chk("b_s0_count", b_count, 9); chk("b_s0_wrap", b_wrap, 0); chk("b_s0_sat", b_sat, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("b_s%0d_count", i), b_count, 9);
      chk($sformatf("b_s%0d_wrap", i), b_wrap, 1);
      chk($sformatf("b_s%0d_sat", i), b_sat, 1);
    end
    b_enable = 1'b0;
    tick(); chk("b_idle_wrap", b_wrap, 0); chk("b_idle_sat", b_sat, 1); chk("b_idle_count", b_count, 9);
    b_load = 1'b1; b_lv = 4'd3;
    tick(); chk("b_load_keeps_sat", b_sat, 1); chk("b_load3", b_count, 3);
    b_load = 1'b0; b_clear = 1'b1;
    tick(); chk("b_clear_count", b_count, 0); chk("b_clear_sat", b_sat, 0);
    b_clear = 1'b0; b_enable = 1'b1; b_up = 1'b0;
    tick(); chk("b_dn_sat_count", b_count, 0); chk("b_dn_sat_wrap", b_wrap, 1); chk("b_dn_sat_sat", b_sat, 1);

    // ---------------- c: natural binary wrap, direction toggle ----------------
    c_reset = 1'b0; c_enable = 1'b1; c_up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk($sformatf("c_up_count_%0d", i), c_count, i % 16);
      chk($sformatf("c_up_wrap_%0d", i), c_wrap, (i == 16) ? 1 : 0);
    end
    c_up = 1'b0;
    tick(); chk("c_dn_count0", c_count, 0); chk("c_dn_wrap0", c_wrap, 0);
    tick(); chk("c_dn_count1", c_count, 15); chk("c_dn_wrap1", c_wrap, 1);
    chk("c_sat", c_sat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
